// File: rtl/sensor_init_seq_pkg.sv
// Shared types and default build constants for the sensor bring-up sequencer.
// Init-table entries are {reg_addr[15:0], data[7:0]}; reg_addr 16'hFFFF marks a delay entry.
package sensor_init_seq_pkg;

  localparam logic [6:0]  I2C_SLAVE_ADDR     = 7'h36;
  localparam int          NUM_REGISTERS      = 4;
  localparam int          NUM_CLK_FOR_1HZ    = 50_000_000;
  localparam int          NUM_CLK_FOR_400KHZ = 125;
  localparam int          DEF_MAX_RETRY      = 3;
  localparam logic [15:0] I2C_DELAY_TAG      = 16'hFFFF;

  // Entry 0 sits in the least significant 24 bits.
  localparam logic [NUM_REGISTERS*24-1:0] I2C_INIT_TABLE =
    {24'h4000AB, 24'hFFFF05, 24'h010001, 24'h301234};

  typedef struct packed {
    logic [15:0] reg_addr;
    logic [7:0]  data;
  } init_entry_t;

  typedef enum logic [1:0] {
    BYTE_DEV = 2'd0,
    BYTE_AHI = 2'd1,
    BYTE_ALO = 2'd2,
    BYTE_DAT = 2'd3
  } byte_sel_t;

  function automatic logic [7:0] entry_byte(input byte_sel_t   sel,
                                            input init_entry_t e,
                                            input logic [6:0]  slave);
    logic [7:0] b;
    b = {slave, 1'b0};
    case (sel)
      BYTE_AHI: b = e.reg_addr[15:8];
      BYTE_ALO: b = e.reg_addr[7:0];
      BYTE_DAT: b = e.data;
      default:  b = {slave, 1'b0};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sensor_init_seq_rom.sv
// Synchronous-read init-table ROM; data appears one clock after addr.
// Contents come from the TABLE parameter, entry i at bits [i*24 +: 24].
module sensor_init_seq_rom
  import sensor_init_seq_pkg::*;
#(
  parameter int                  DEPTH = 1,
  parameter int                  AW    = 1,
  parameter logic [DEPTH*24-1:0] TABLE = '0
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output init_entry_t   data
);

  always_ff @(posedge clk) begin
    if (int'(addr) < DEPTH) data <= TABLE[int'(addr)*24 +: 24];
    else                    data <= '0;
  end

endmodule

// File: rtl/sensor_init_seq.sv
// Walks the init table and writes each register over I2C (DEV, AHI, ALO, DAT), with NACK abort/retry.
// Command outputs are registered and held stable while ready is low; each byte waits for its response.
module sensor_init_seq
  import sensor_init_seq_pkg::*;
#(
  parameter logic [6:0]              SLAVE_ADDR = I2C_SLAVE_ADDR,
  parameter int                      NUM_ENTRY  = NUM_REGISTERS,
  parameter logic [NUM_ENTRY*24-1:0] INIT_TABLE = I2C_INIT_TABLE,
  parameter int                      PWRUP_CLKS = NUM_CLK_FOR_1HZ,
  parameter int                      DLY_UNIT   = NUM_CLK_FOR_400KHZ,
  parameter int                      MAX_RETRY  = DEF_MAX_RETRY,
  localparam int                     IDX_W      = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start,
  output logic             i2c_cmd_valid,
  input  logic             i2c_cmd_ready,
  output logic             i2c_cmd_start,
  output logic             i2c_cmd_stop,
  output logic [7:0]       i2c_cmd_byte,
  input  logic             i2c_rsp_valid,
  input  logic             i2c_rsp_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int CNT_MAX = (PWRUP_CLKS > 255*DLY_UNIT) ? PWRUP_CLKS : 255*DLY_UNIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RT_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_CMD, S_WAIT_RSP, S_ABORT, S_ABORT_RSP,
    S_DLY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t          state, state_d;
  byte_sel_t       sel, sel_d;
  logic [IDX_W-1:0] idx, idx_d, err_idx_d;
  logic [RT_W-1:0]  retry, retry_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             cmd_valid_d, cmd_start_d, cmd_stop_d, done_d, error_d;
  logic [7:0]       cmd_byte_d;
  logic             xfer, load_cmd;
  byte_sel_t        load_sel;
  init_entry_t      rom_q;

  // ROM is addressed with the next index so the entry is already valid during FETCH.
  sensor_init_seq_rom #(.DEPTH(NUM_ENTRY), .AW(IDX_W), .TABLE(INIT_TABLE)) u_rom (
    .clk  (clk),
    .addr (idx_d),
    .data (rom_q)
  );

  assign xfer = i2c_cmd_valid & i2c_cmd_ready;
  assign busy = (state != S_IDLE);

  always_comb begin
    state_d     = state;
    sel_d       = sel;
    idx_d       = idx;
    retry_d     = retry;
    cnt_d       = cnt;
    cmd_valid_d = i2c_cmd_valid;
    cmd_start_d = i2c_cmd_start;
    cmd_stop_d  = i2c_cmd_stop;
    cmd_byte_d  = i2c_cmd_byte;
    done_d      = done;
    error_d     = error;
    err_idx_d   = err_idx;
    load_cmd    = 1'b0;
    load_sel    = BYTE_DEV;

    case (state)
      S_IDLE: if (start) begin
        done_d  = 1'b0;
        error_d = 1'b0;
        idx_d   = '0;
        retry_d = '0;
        cnt_d   = CNT_W'(PWRUP_CLKS);
        state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (cnt == '0) state_d = S_FETCH;
        else           cnt_d   = cnt - 1'b1;
      end
      S_FETCH: begin
        retry_d = '0;
        if (rom_q.reg_addr == I2C_DELAY_TAG) begin
          cnt_d   = CNT_W'(32'(rom_q.data) * DLY_UNIT);
          state_d = S_DLY;
        end else begin
          load_cmd = 1'b1;
        end
      end
      S_CMD: if (xfer) begin
        cmd_valid_d = 1'b0;
        state_d     = S_WAIT_RSP;
      end
      S_WAIT_RSP: if (i2c_rsp_valid) begin
        if (i2c_rsp_nack) begin
          cmd_valid_d = 1'b1;
          cmd_start_d = 1'b0;
          cmd_stop_d  = 1'b1;
          cmd_byte_d  = 8'hFF;
          state_d     = S_ABORT;
        end else if (sel == BYTE_DAT) begin
          state_d = S_NEXT;
        end else begin
          load_cmd = 1'b1;
          load_sel = byte_sel_t'(sel + 2'd1);
        end
      end
      S_ABORT: if (xfer) begin
        cmd_valid_d = 1'b0;
        state_d     = S_ABORT_RSP;
      end
      // Response to the abort STOP is consumed but its ACK/NACK is irrelevant.
      S_ABORT_RSP: if (i2c_rsp_valid) begin
        if (retry < RT_W'(MAX_RETRY)) begin
          retry_d  = retry + 1'b1;
          load_cmd = 1'b1;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_DLY: begin
        if (cnt == '0) state_d = S_NEXT;
        else           cnt_d   = cnt - 1'b1;
      end
      S_NEXT: begin
        if (idx == IDX_W'(NUM_ENTRY - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        error_d   = 1'b1;
        err_idx_d = idx;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (load_cmd) begin
      sel_d       = load_sel;
      cmd_valid_d = 1'b1;
      cmd_start_d = (load_sel == BYTE_DEV);
      cmd_stop_d  = (load_sel == BYTE_DAT);
      cmd_byte_d  = entry_byte(load_sel, rom_q, SLAVE_ADDR);
      state_d     = S_CMD;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= S_IDLE;
      sel           <= BYTE_DEV;
      idx           <= '0;
      retry         <= '0;
      cnt           <= '0;
      i2c_cmd_valid <= 1'b0;
      i2c_cmd_start <= 1'b0;
      i2c_cmd_stop  <= 1'b0;
      i2c_cmd_byte  <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_idx       <= '0;
    end else begin
      state         <= state_d;
      sel           <= sel_d;
      idx           <= idx_d;
      retry         <= retry_d;
      cnt           <= cnt_d;
      i2c_cmd_valid <= cmd_valid_d;
      i2c_cmd_start <= cmd_start_d;
      i2c_cmd_stop  <= cmd_stop_d;
      i2c_cmd_byte  <= cmd_byte_d;
      done          <= done_d;
      error         <= error_d;
      err_idx       <= err_idx_d;
    end
  end

endmodule

// File: tb/tb_sensor_init_seq.sv
// Bench for sensor_init_seq: I2C master BFM with scripted NACK/stall, expected commands in a scoreboard queue.
module tb_sensor_init_seq;

  localparam logic [6:0]  SLV = 7'h10;
  localparam logic [95:0] TBL = {24'h4000AB, 24'hFFFF05, 24'h010001, 24'h301234};

  typedef struct packed {
    logic       s;
    logic       p;
    logic [7:0] b;
    logic       nack;
  } exp_t;

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       start = 1'b0;
  logic       i2c_cmd_ready = 1'b1;
  logic       i2c_rsp_valid = 1'b0;
  logic       i2c_rsp_nack = 1'b0;
  logic       i2c_cmd_valid, i2c_cmd_start, i2c_cmd_stop;
  logic [7:0] i2c_cmd_byte;
  logic       busy, done, error;
  logic [1:0] err_idx;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   xfer_cyc[$];
  exp_t bfm_e;
  logic pend = 1'b0, pend_nack = 1'b0, spur = 1'b0, stalling = 1'b0;
  int   stall_at = 0, stall_left = 0, stalled = 0;

  sensor_init_seq #(
    .SLAVE_ADDR (SLV),
    .NUM_ENTRY  (4),
    .INIT_TABLE (TBL),
    .PWRUP_CLKS (10),
    .DLY_UNIT   (20),
    .MAX_RETRY  (3)
  ) dut (
    .clk           (clk),
    .areset_n      (areset_n),
    .start         (start),
    .i2c_cmd_valid (i2c_cmd_valid),
    .i2c_cmd_ready (i2c_cmd_ready),
    .i2c_cmd_start (i2c_cmd_start),
    .i2c_cmd_stop  (i2c_cmd_stop),
    .i2c_cmd_byte  (i2c_cmd_byte),
    .i2c_rsp_valid (i2c_rsp_valid),
    .i2c_rsp_nack  (i2c_rsp_nack),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .err_idx       (err_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Expected commands for one table entry; nack_at marks the byte the slave refuses (-1: none).
  task automatic push_entry(input int e, input int nack_at);
    logic [23:0] ent;
    logic [7:0]  bs [4];
    ent   = TBL[e*24 +: 24];
    bs[0] = {SLV, 1'b0};
    bs[1] = ent[23:16];
    bs[2] = ent[15:8];
    bs[3] = ent[7:0];
    if (ent[23:8] != 16'hFFFF) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back('{s: (i == 0), p: (i == 3), b: bs[i], nack: (i == nack_at)});
        if (i == nack_at) begin
          exp_q.push_back('{s: 1'b0, p: 1'b1, b: 8'hFF, nack: 1'b0});
          break;
        end
      end
    end
  endtask

  task automatic push_all_ack();
    for (int e = 0; e < 4; e++) push_entry(e, -1);
  endtask

  task automatic new_test();
    exp_q.delete();
    xfer_cyc.delete();
    stalled = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  // I2C master model: decides ready, accepts commands, answers one clock later.
  always @(negedge clk) begin
    cyc++;
    if (!areset_n) begin
      i2c_rsp_valid = 1'b0;
      i2c_rsp_nack  = 1'b0;
      i2c_cmd_ready = 1'b1;
      pend          = 1'b0;
      stalling      = 1'b0;
    end else begin
      i2c_rsp_valid = 1'b0;
      i2c_rsp_nack  = 1'b0;
      if (pend) begin
        i2c_rsp_valid = 1'b1;
        i2c_rsp_nack  = pend_nack;
        pend          = 1'b0;
      end else if (spur) begin
        i2c_rsp_valid = 1'b1;
        i2c_rsp_nack  = 1'b1;
        spur          = 1'b0;
      end
      if (!stalling && stall_left > 0 && xfer_cyc.size() == stall_at && i2c_cmd_valid)
        stalling = 1'b1;
      if (stalling) begin
        i2c_cmd_ready = 1'b0;
        chk("stall_valid", 32'(i2c_cmd_valid), 32'd1);
        if (exp_q.size() > 0) chk("stall_byte", 32'(i2c_cmd_byte), 32'(exp_q[0].b));
        stall_left--;
        stalled++;
        if (stall_left == 0) stalling = 1'b0;
      end else begin
        i2c_cmd_ready = 1'b1;
      end
      if (i2c_cmd_valid && i2c_cmd_ready) begin
        if (exp_q.size() == 0) begin
          chk("cmd_unexpected", {23'd0, i2c_cmd_valid, i2c_cmd_byte}, 32'd0);
        end else begin
          bfm_e = exp_q.pop_front();
          chk("cmd_byte", 32'(i2c_cmd_byte), 32'(bfm_e.b));
          chk("cmd_start", 32'(i2c_cmd_start), 32'(bfm_e.s));
          chk("cmd_stop", 32'(i2c_cmd_stop), 32'(bfm_e.p));
          pend      = 1'b1;
          pend_nack = bfm_e.nack;
        end
        xfer_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_cmd_valid", 32'(i2c_cmd_valid), 32'd0);
    chk("rst_cmd_start", 32'(i2c_cmd_start), 32'd0);
    chk("rst_cmd_stop", 32'(i2c_cmd_stop), 32'd0);
    chk("rst_cmd_byte", 32'(i2c_cmd_byte), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    @(negedge clk) areset_n = 1'b1;

    // All ACK, with a delay entry between entries 1 and 3 and a stray response during power-up.
    new_test();
    push_all_ack();
    pulse_start();
    chk("t1_busy", 32'(busy), 32'd1);
    spur = 1'b1;
    wait_end("t1_timeout", 2000);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_left", 32'(exp_q.size()), 32'd0);
    chk("t1_ncmd", 32'(xfer_cyc.size()), 32'd12);
    if (xfer_cyc.size() >= 9)
      chk("t4_dly_gap", 32'((xfer_cyc[8] - xfer_cyc[7]) >= 100), 32'd1);

    // One NACK on the AHI byte of entry 1.
    new_test();
    push_entry(0, -1);
    push_entry(1, 1);
    push_entry(1, -1);
    push_entry(3, -1);
    pulse_start();
    wait_end("t2_timeout", 2000);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_error", 32'(error), 32'd0);
    chk("t2_left", 32'(exp_q.size()), 32'd0);
    chk("t2_ncmd", 32'(xfer_cyc.size()), 32'd15);

    // Entry 1 NACKs its DEV byte on every attempt.
    new_test();
    push_entry(0, -1);
    repeat (4) push_entry(1, 0);
    pulse_start();
    chk("t3_done_cleared", 32'(done), 32'd0);
    wait_end("t3_timeout", 2000);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_err_idx", 32'(err_idx), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_left", 32'(exp_q.size()), 32'd0);
    chk("t3_ncmd", 32'(xfer_cyc.size()), 32'd12);

    // Ready held low for 50 clocks on the AHI byte of entry 0.
    new_test();
    stall_at   = 1;
    stall_left = 50;
    push_all_ack();
    pulse_start();
    wait_end("t5_timeout", 2000);
    chk("t5_stalled", 32'(stalled), 32'd50);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_left", 32'(exp_q.size()), 32'd0);

    // Reset while the DAT byte of entry 0 waits for ready, then a clean rerun.
    new_test();
    stall_at   = 3;
    stall_left = 10;
    push_all_ack();
    pulse_start();
    begin
      int n;
      n = 0;
      while (xfer_cyc.size() < 3 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t6_reach_dat", 32'(n < 500), 32'd1);
    end
    repeat (3) @(negedge clk);
    chk("t6_mid_valid", 32'(i2c_cmd_valid), 32'd1);
    chk("t6_mid_byte", 32'(i2c_cmd_byte), 32'h34);
    @(posedge clk);
    #2 areset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(i2c_cmd_valid), 32'd0);
    chk("t6_rst_stop", 32'(i2c_cmd_stop), 32'd0);
    chk("t6_rst_byte", 32'(i2c_cmd_byte), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    chk("t6_rst_error", 32'(error), 32'd0);
    new_test();
    stall_left = 0;
    @(negedge clk);
    @(negedge clk) areset_n = 1'b1;
    push_all_ack();
    pulse_start();
    repeat (30) @(negedge clk);
    chk("t6_busy_mid", 32'(busy), 32'd1);
    pulse_start();
    wait_end("t6_timeout", 2000);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_error", 32'(error), 32'd0);
    chk("t6_left", 32'(exp_q.size()), 32'd0);
    chk("t6_ncmd", 32'(xfer_cyc.size()), 32'd12);
    repeat (20) @(negedge clk);
    chk("t6_idle_after", 32'(busy), 32'd0);
    chk("t6_no_extra", 32'(xfer_cyc.size()), 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
